multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised, multi-channel successor to the single-channel edge detector. Each of N asynchronous inputs passes through a synchroniser and a debounce filter. A pulse is produced on rising, falling or both edges of the filtered level, according to a run-time mode. Detected events are also held in per-channel sticky flags and counted in a saturating counter. The block sits between raw panel/sensor inputs (buttons, switches, echo lines) and the control FSMs.

## Interface
Parameters:
- N, default 4: number of channels (≥1).
- SYNC_STAGES, default 2: synchroniser flip-flops per channel (≥2).
- DEBOUNCE, default 4: consecutive stable cycles required to accept a new level (≥1).
- CW, default 8: event counter width (≥2).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sinal  input  N  raw asynchronous inputs.
- modo  input  2  edge select, shared by all channels: 00 none, 01 rising, 10 falling, 11 both.
- limpa  input  N  per-channel clear for `evento`.
- zera_contagem  input  1  clears `contagem`.
- nivel  output  N  debounced level per channel.
- pulso  output  N  one-cycle event pulse per channel.
- evento  output  N  sticky event flags.
- qualquer  output  1  OR of `evento`; combinational.
- contagem  output  CW  saturating event count.

## Operation
- **Reset.** Reset is synchronous and active-high. While reset is sampled high, all synchroniser stages, debounce counters, `nivel`, `pulso`, `evento` and `contagem` go to 0 at the clock edge. A reset mid-debounce discards the partial count.
- **Synchroniser.** `s[i]` is `sinal[i]` after a SYNC_STAGES-deep shift chain.
- **Debounce.** Each channel has a counter `cnt[i]`, width clog2(DEBOUNCE+1). Per cycle:
  - if `s[i]` == `nivel[i]`: `cnt` ← 0;
  - else if `cnt` == DEBOUNCE-1: `nivel[i]` ← `s[i]` and `cnt` ← 0;
  - else: `cnt` ← `cnt`+1.
  - Effect: any excursion of `s[i]` shorter than DEBOUNCE cycles is rejected entirely. With DEBOUNCE=1, `nivel` follows `s` with one cycle of delay.
- **Edge.** At the edge where `nivel[i]` takes a new value v, `pulso[i]` is registered 1 if (v=1 and `modo[0]`) or (v=0 and `modo[1]`); otherwise it is 0. `pulso[i]` is 0 on every other cycle. Filtering continues in mode 00; only the pulses are suppressed.
- **Sticky flags.** `evento[i]` ← (`evento[i]` & ~`limpa[i]`) | `pulso_next[i]`. If a set and a clear occur in the same cycle, the set wins, so no event is lost. `limpa` has no effect on a flag that is already 0.
- **Counter.** `contagem` ← sat((`zera_contagem` ? 0 : `contagem`) + popcount(`pulso_next`)), saturating at 2^CW-1. Pulses arriving in the same cycle as `zera_contagem` are counted after the clear. Once saturated, the counter stays at 2^CW-1 until `zera_contagem`.
- **Mode changes.** A new `modo` applies to the edge-decision at the next clock edge. There is no retroactive pulse for a level change that has already been accepted.
- **Input high at reset release.** If `sinal[i]` is 1 when reset is released, `nivel[i]` rises after the normal latency and produces a rising event. This is intended.

## Timing
- **Latency.** Suppose `sinal[i]` changes and then holds stable from clock edge 0 onward. `nivel[i]` and `pulso[i]` update at edge SYNC_STAGES+DEBOUNCE-1 (edge 5 with defaults). `evento[i]` and `contagem` update at the same edge.
- **Pulse width.** `pulso` is exactly 1 cycle wide. Two events on the same channel are at least DEBOUNCE cycles apart.
- **Registered outputs.** `nivel`, `pulso`, `evento` and `contagem` are all registered. `qualquer` is combinational from `evento`.
- **Channel independence.** Channels are fully independent. Any subset may pulse in the same cycle, and `contagem` then adds the number of simultaneous pulses.

## Test plan
1. **Single rise, defaults.** N=4, modo=01. Hold `sinal[0]` 0→1 from edge 0 → `nivel[0]`=1 and `pulso[0]`=1 for one cycle at edge 5; `evento[0]`=1; `qualquer`=1; `contagem`=1.
2. **Glitch rejection.** DEBOUNCE=4. Apply a 3-cycle high glitch on `sinal[1]` → no change on `nivel[1]`, `pulso` or `contagem`. A 4-cycle high → one pulse. Returning low afterwards with modo=01 → no pulse.
3. **Mode sweep.** For each modo, apply a full 0→1→0 cycle on one channel with a 10-cycle hold. modo=00 → 0 pulses; 01 → 1 (on rise); 10 → 1 (on fall); 11 → 2. `nivel` tracks the input in all modes.
4. **Simultaneous events.** modo=11. Toggle all 4 inputs together → `pulso`=4'b1111 for one cycle and `contagem` += 4. In the same cycle, assert `limpa`=4'b1111 with flags already set → `evento` stays 4'b1111.
5. **Counter saturation and clear.** CW=2. Generate 5 events → `contagem` = 3 after the 3rd and stays 3. Assert `zera_contagem` in the same cycle as a pulse → `contagem`=1.
6. **Reset mid-operation.** Assert reset 2 cycles into a debounce window → all outputs 0 at the next edge. With `sinal` still high, release reset → rising pulse SYNC_STAGES+DEBOUNCE-1 edges after release.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter and
// mode-selected edge pulse, with sticky flags and a shared saturating counter.
module multi_edge_detector #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CW          = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  sinal,
    input  logic [1:0]    modo,
    input  logic [N-1:0]  limpa,
    input  logic          zera_contagem,
    output logic [N-1:0]  nivel,
    output logic [N-1:0]  pulso,
    output logic [N-1:0]  evento,
    output logic          qualquer,
    output logic [CW-1:0] contagem
);

    localparam int unsigned DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int unsigned PW = $clog2(N + 1);
    localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [N-1:0]  r_sync [SYNC_STAGES];
    logic [DW-1:0] r_cnt  [N];

    logic [N-1:0]  w_s;
    logic [N-1:0]  w_accept;
    logic [DW-1:0] w_cnt_next [N];
    logic [N-1:0]  w_nivel_next;
    logic [N-1:0]  w_pulso_next;
    logic [N-1:0]  w_evento_next;
    logic [PW-1:0] w_pop;
    logic [SW-1:0] w_sum;
    logic [CW-1:0] w_contagem_next;

    // Synchroniser shift chain; the last stage is the filter input.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= sinal;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Debounce: a new level is accepted after DEBOUNCE consecutive differing samples.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_s[i] == nivel[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_accept[i]   = 1'b1;
                w_cnt_next[i] = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + DW'(1);
            end
        end
    end

    assign w_nivel_next = nivel ^ w_accept;

    // Edge decision uses the level being accepted and the current mode.
    always_comb begin
        w_pulso_next = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_accept[i]) begin
                w_pulso_next[i] = w_s[i] ? modo[0] : modo[1];
            end
        end
    end

    // A set in the same cycle as a clear wins, so no event is lost.
    assign w_evento_next = (evento & ~limpa) | w_pulso_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_pop = w_pop + PW'(w_pulso_next[i]);
        end
    end

    // Clear first, then add this cycle's pulses, then saturate.
    always_comb begin
        w_sum           = (zera_contagem ? SW'(0) : SW'(contagem)) + SW'(w_pop);
        w_contagem_next = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CW-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                r_cnt[i] <= '0;
            end
            nivel    <= '0;
            pulso    <= '0;
            evento   <= '0;
            contagem <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            nivel    <= w_nivel_next;
            pulso    <= w_pulso_next;
            evento   <= w_evento_next;
            contagem <= w_contagem_next;
        end
    end

    assign qualquer = |evento;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: default instance plus a CW=2 instance
// sharing the same stimulus for saturation checks.
module tb_multi_edge_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] sinal;
    logic [1:0] modo;
    logic [3:0] limpa;
    logic       zera_contagem;

    logic [3:0] nivel, pulso, evento;
    logic       qualquer;
    logic [7:0] contagem;

    logic [3:0] nivel_2, pulso_2, evento_2;
    logic       qualquer_2;
    logic [1:0] contagem_2;

    int n_checks = 0;
    int n_pass   = 0;
    int pcnt     = 0;

    always #5 clock = ~clock;

    multi_edge_detector dut (
        .clock(clock), .reset(reset), .sinal(sinal), .modo(modo), .limpa(limpa),
        .zera_contagem(zera_contagem), .nivel(nivel), .pulso(pulso), .evento(evento),
        .qualquer(qualquer), .contagem(contagem)
    );

    multi_edge_detector #(.CW(2)) dut_sat (
        .clock(clock), .reset(reset), .sinal(sinal), .modo(modo), .limpa(limpa),
        .zera_contagem(zera_contagem), .nivel(nivel_2), .pulso(pulso_2), .evento(evento_2),
        .qualquer(qualquer_2), .contagem(contagem_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance n cycles, accumulating the number of pulse bits seen.
    task automatic run(input int n);
        repeat (n) begin
            tick();
            pcnt += $countones(pulso);
        end
    endtask

    initial begin
        logic [1:0] m;
        int exp_sat;

        reset = 1'b1; sinal = '0; modo = 2'b01; limpa = '0; zera_contagem = 1'b0;
        repeat (3) tick();
        check("rst_nivel", 32'(nivel), 32'h0);
        check("rst_pulso", 32'(pulso), 32'h0);
        check("rst_evento", 32'(evento), 32'h0);
        check("rst_qualquer", 32'(qualquer), 32'h0);
        check("rst_contagem", 32'(contagem), 32'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Single rise on channel 0: visible at edge 5
        sinal = 4'b0001;
        tick();
        repeat (4) tick();
        check("t1_nivel_e4", 32'(nivel), 32'h0);
        check("t1_pulso_e4", 32'(pulso), 32'h0);
        tick();
        check("t1_nivel_e5", 32'(nivel), 32'h1);
        check("t1_pulso_e5", 32'(pulso), 32'h1);
        check("t1_evento", 32'(evento), 32'h1);
        check("t1_qualquer", 32'(qualquer), 32'h1);
        check("t1_contagem", 32'(contagem), 32'h1);
        tick();
        check("t1_pulso_e6", 32'(pulso), 32'h0);
        check("t1_contagem_e6", 32'(contagem), 32'h1);

        // Glitch rejection: 3 cycles rejected, 4 accepted, fall ignored in mode 01
        pcnt = 0;
        sinal = 4'b0011;
        run(3);
        sinal = 4'b0001;
        run(8);
        check("t2_glitch_pulses", 32'(pcnt), 32'h0);
        check("t2_glitch_nivel", 32'(nivel), 32'h1);
        check("t2_glitch_cont", 32'(contagem), 32'h1);
        pcnt = 0;
        sinal = 4'b0011;
        run(4);
        sinal = 4'b0001;
        run(10);
        check("t2_accept_pulses", 32'(pcnt), 32'h1);
        check("t2_nivel_back", 32'(nivel), 32'h1);
        check("t2_evento", 32'(evento), 32'h3);
        check("t2_contagem", 32'(contagem), 32'h2);
        limpa = 4'b0011;
        tick();
        limpa = 4'b0000;
        check("t2_cleared", 32'(evento), 32'h0);
        check("t2_qualquer_off", 32'(qualquer), 32'h0);

        // Mode sweep on channel 2
        for (int k = 0; k < 4; k++) begin
            m = 2'(k);
            modo = m;
            pcnt = 0;
            sinal = 4'b0101;
            run(10);
            check($sformatf("t3_m%0d_rise_nivel", k), 32'(nivel), 32'h5);
            check($sformatf("t3_m%0d_rise_pulses", k), 32'(pcnt), 32'(m[0]));
            pcnt = 0;
            sinal = 4'b0001;
            run(10);
            check($sformatf("t3_m%0d_fall_nivel", k), 32'(nivel), 32'h1);
            check($sformatf("t3_m%0d_fall_pulses", k), 32'(pcnt), 32'(m[1]));
        end
        check("t3_contagem", 32'(contagem), 32'd6);

        // Simultaneous events, then set-wins-over-clear
        modo = 2'b11;
        sinal = 4'b1110;
        repeat (5) tick();
        check("t4a_pulso_e4", 32'(pulso), 32'h0);
        tick();
        check("t4a_pulso", 32'(pulso), 32'hF);
        check("t4a_contagem", 32'(contagem), 32'd10);
        check("t4a_evento", 32'(evento), 32'hF);
        repeat (6) tick();
        sinal = 4'b0001;
        repeat (5) tick();
        limpa = 4'b1111;
        tick();
        limpa = 4'b0000;
        check("t4b_pulso", 32'(pulso), 32'hF);
        check("t4b_evento_kept", 32'(evento), 32'hF);
        check("t4b_contagem", 32'(contagem), 32'd14);
        tick();
        check("t4b_pulso_off", 32'(pulso), 32'h0);
        limpa = 4'b1111;
        tick();
        limpa = 4'b0000;
        check("t4c_evento_clr", 32'(evento), 32'h0);
        check("t4c_qualquer", 32'(qualquer), 32'h0);

        // Saturation on the CW=2 instance
        check("t5_pre_sat", 32'(contagem_2), 32'd3);
        zera_contagem = 1'b1;
        tick();
        zera_contagem = 1'b0;
        check("t5_zero", 32'(contagem_2), 32'd0);
        check("t5_zero_wide", 32'(contagem), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            sinal = sinal ^ 4'b0001;
            run(8);
            exp_sat = (k > 3) ? 3 : k;
            check($sformatf("t5_sat_%0d", k), 32'(contagem_2), 32'(exp_sat));
        end
        check("t5_wide_count", 32'(contagem), 32'd5);
        sinal = sinal ^ 4'b0001;
        repeat (5) tick();
        zera_contagem = 1'b1;
        tick();
        zera_contagem = 1'b0;
        check("t5_clr_pulse", 32'(pulso_2), 32'h1);
        check("t5_clr_and_count", 32'(contagem_2), 32'd1);
        check("t5_clr_and_count_w", 32'(contagem), 32'd1);
        repeat (6) tick();

        // Reset two cycles into a debounce window, release with input still high
        sinal = 4'b0011;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("t6_rst_nivel", 32'(nivel), 32'h0);
        check("t6_rst_pulso", 32'(pulso), 32'h0);
        check("t6_rst_evento", 32'(evento), 32'h0);
        check("t6_rst_contagem", 32'(contagem), 32'h0);
        check("t6_rst_cont_sat", 32'(contagem_2), 32'h0);
        check("t6_rst_qualquer", 32'(qualquer), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        check("t6_pre_pulso", 32'(pulso), 32'h0);
        check("t6_pre_nivel", 32'(nivel), 32'h0);
        tick();
        check("t6_nivel", 32'(nivel), 32'h3);
        check("t6_pulso", 32'(pulso), 32'h3);
        check("t6_evento", 32'(evento), 32'h3);
        check("t6_contagem", 32'(contagem), 32'd2);
        tick();
        check("t6_pulso_off", 32'(pulso), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
